// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential multiply-accumulate for one neuron.
// Drives the weights ROM address, multiplies each signed weight by a streamed
// signed activation, then rescales, saturates and optionally applies ReLU.
// The signed 8-bit result leaves over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a neuron (honoured only in IDLE)
//   base_addr         first weight address, sampled on start
//   num_terms         number of MAC terms (0 means 256), sampled on start
//   rom_addr          registered address to the weights ROM
//   rom_data          signed weight returned by the ROM
//   x_data/x_valid    signed activation stream; x_ready high in RUN
//   y_data/y_valid    signed result; held until y_ready
//   busy              high in RUN and OUT
module neuron_mac_seq #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 6,
  parameter int unsigned RELU  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] num_terms,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [7:0] x_data,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [7:0] y_data,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       busy
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned PROD_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               addr_q, addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               y_data_q, y_data_d;
  logic                     y_valid_q, y_valid_d;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic [7:0]               res_c;

  // Signed 8x8 product; operands sign-extended before multiplying.
  assign prod_c = PROD_W'($signed(x_data)) * PROD_W'($signed(rom_data));

  // Rescale, saturate to the int8 range, then optional ReLU.
  assign shifted_c = acc_q >>> SHIFT;

  always_comb begin
    res_c = shifted_c[7:0];
    if (shifted_c > SAT_MAX) begin
      res_c = 8'h7f;
    end else if (shifted_c < SAT_MIN) begin
      res_c = 8'h80;
    end
    if ((RELU != 0) && res_c[7]) begin
      res_c = 8'h00;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = (num_terms == 8'd0) ? CNT_W'(256) : {1'b0, num_terms};
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A stall holds address, accumulator and count, so the ROM keeps
        // presenting the same weight until the activation arrives.
        if (x_valid) begin
          acc_d  = acc_q + ACC_W'(prod_c);
          addr_d = addr_q + 8'd1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        // First OUT cycle captures the final accumulator into y_data.
        if (!y_valid_q) begin
          y_data_d  = res_c;
          y_valid_d = 1'b1;
        end else if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign rom_addr = addr_q;
  assign y_data   = y_data_q;
  assign y_valid  = y_valid_q;
  assign x_ready  = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: a ReLU and a linear instance run in lockstep
// against a negedge-registered weights ROM model.
module tb_neuron_mac_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] num_terms;
  logic [7:0] x_data;
  logic       x_valid;
  logic       y_ready;

  logic [7:0] rom_addr_r, rom_addr_l;
  logic [7:0] rom_data_r, rom_data_l;
  logic       x_ready_r, x_ready_l;
  logic [7:0] y_data_r, y_data_l;
  logic       y_valid_r, y_valid_l;
  logic       busy_r, busy_l;

  logic [7:0] rom [256];
  logic [7:0] xs [256];

  int checks;
  int failures;

  neuron_mac_seq #(.ACC_W(24), .SHIFT(6), .RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_terms(num_terms), .rom_addr(rom_addr_r), .rom_data(rom_data_r),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_r),
    .y_data(y_data_r), .y_valid(y_valid_r), .y_ready(y_ready), .busy(busy_r)
  );

  neuron_mac_seq #(.ACC_W(24), .SHIFT(6), .RELU(0)) u_dut_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_terms(num_terms), .rom_addr(rom_addr_l), .rom_data(rom_data_l),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_l),
    .y_data(y_data_l), .y_valid(y_valid_l), .y_ready(y_ready), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM registers its output on negedge.
  always @(negedge clk) begin
    rom_data_r <= rom[rom_addr_r];
    rom_data_l <= rom[rom_addr_l];
  end

  typedef struct {
    logic [7:0] base;
    int         n;
    logic [7:0] w [4];
    logic [7:0] x [4];
    logic [7:0] y_relu;
    logic [7:0] y_lin;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [7:0] b, input int n,
                              input logic [31:0] wp, input logic [31:0] xp,
                              input logic [7:0] yr, input logic [7:0] yl);
    vec_t v;
    v.base = b;
    v.n = n;
    for (int i = 0; i < 4; i++) begin
      v.w[i] = wp[31-8*i -: 8];
      v.x[i] = xp[31-8*i -: 8];
    end
    v.y_relu = yr;
    v.y_lin = yl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      rom[8'(v.base + 8'(i))] = v.w[i];
      xs[i] = v.x[i];
    end
  endtask

  // One neuron: start, stream n activations, check latency, result, handshake.
  task automatic run_neuron(input logic [7:0] base, input int n, input bit stall,
                            input bit hold, input logic [7:0] exp_r, input logic [7:0] exp_l);
    int lat;
    base_addr = base;
    num_terms = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 8'd0;
    num_terms = 8'd0;
    chk("busy_after_start", {31'b0, busy_r}, 32'd1);
    chk("addr_after_start", {24'b0, rom_addr_r}, {24'b0, base});
    chk("x_ready_run", {30'b0, x_ready_r, x_ready_l}, 32'd3);
    for (int i = 0; i < n; i++) begin
      if (stall && i == 2) begin
        x_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          start = (s == 1);
          base_addr = 8'd99;
          num_terms = 8'd1;
          tick();
          chk("stall_addr_hold", {24'b0, rom_addr_r}, {24'b0, 8'(base + 8'd2)});
          chk("stall_busy", {31'b0, busy_r}, 32'd1);
        end
        start = 1'b0;
        base_addr = 8'd0;
        num_terms = 8'd0;
      end
      x_valid = 1'b1;
      x_data = xs[i];
      tick();
      chk("addr_step", {24'b0, rom_addr_r}, {24'b0, 8'(base + 8'(i + 1))});
    end
    x_valid = 1'b0;
    x_data = 8'd0;
    chk("y_valid_not_yet", {31'b0, y_valid_r}, 32'd0);
    chk("x_ready_out", {30'b0, x_ready_r, x_ready_l}, 32'd0);
    lat = 0;
    while (!y_valid_r && lat < 8) begin
      tick();
      lat++;
    end
    chk("latency_after_last_mac", 32'(lat), 32'd1);
    chk("y_data_relu", {24'b0, y_data_r}, {24'b0, exp_r});
    chk("y_data_lin", {24'b0, y_data_l}, {24'b0, exp_l});
    chk("y_valid_lin", {31'b0, y_valid_l}, 32'd1);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        tick();
        chk("hold_y_valid", {31'b0, y_valid_r}, 32'd1);
        chk("hold_y_data", {24'b0, y_data_r}, {24'b0, exp_r});
        chk("hold_x_ready", {31'b0, x_ready_r}, 32'd0);
        chk("hold_busy", {31'b0, busy_r}, 32'd1);
      end
      start = 1'b0;
    end
    y_ready = 1'b1;
    start = 1'b1;
    base_addr = 8'd77;
    tick();
    y_ready = 1'b0;
    start = 1'b0;
    base_addr = 8'd0;
    chk("y_valid_drop", {30'b0, y_valid_r, y_valid_l}, 32'd0);
    chk("idle_after_hs", {30'b0, busy_r, busy_l}, 32'd0);
    tick();
    chk("start_at_hs_ignored", {30'b0, busy_r, busy_l}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 8'd0;
    num_terms = 8'd0;
    x_data = 8'd0;
    x_valid = 1'b0;
    y_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'd0;
      xs[i] = 8'd0;
    end

    vecs[0] = mk(8'd0,   4, 32'h4040_C020, 32'h0102_0304, 8'h02, 8'h02);
    vecs[1] = mk(8'd10,  4, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 8'h7F, 8'h7F);
    vecs[2] = mk(8'd10,  4, 32'h8080_8080, 32'h7F7F_7F7F, 8'h00, 8'h80);
    vecs[3] = mk(8'd254, 4, 32'h4040_4040, 32'h0101_0101, 8'h04, 8'h04);
    vecs[4] = mk(8'd30,  2, 32'h03FB_0000, 32'h0A07_0000, 8'h00, 8'hFF);
    vecs[5] = mk(8'd40,  2, 32'h6432_0000, 32'h14F6_0000, 8'h17, 8'h17);

    #2;
    chk("reset_outputs", {rom_addr_r, y_data_r, 5'b0, y_valid_r, x_ready_r, busy_r}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {30'b0, busy_r, x_ready_r}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      run_neuron(vecs[v].base, vecs[v].n, 1'b0, 1'b0, vecs[v].y_relu, vecs[v].y_lin);
    end

    // Stall mid-neuron with a start pulse during RUN, then hold in OUT.
    load_vec(vecs[0]);
    run_neuron(8'd0, 4, 1'b1, 1'b1, 8'h02, 8'h02);

    // 256 terms via num_terms=0: acc=16384, 256 after shift, saturates.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h40;
      xs[i] = 8'h01;
    end
    run_neuron(8'd0, 256, 1'b0, 1'b0, 8'h7F, 8'h7F);

    // Asynchronous reset mid-RUN discards the partial neuron.
    load_vec(vecs[0]);
    base_addr = 8'd0;
    num_terms = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    x_valid = 1'b1;
    x_data = xs[0];
    tick();
    x_data = xs[1];
    tick();
    x_valid = 1'b0;
    chk("pre_reset_y_data", {24'b0, y_data_r}, 32'h7F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {rom_addr_r, y_data_r, 5'b0, y_valid_r, x_ready_r, busy_r}, 32'd0);
    chk("async_reset_lin", {rom_addr_l, y_data_l, 5'b0, y_valid_l, x_ready_l, busy_l}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_neuron(8'd0, 4, 1'b0, 1'b0, 8'h02, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
